// File: rtl/disp_pkg.sv
// Shared types and width helpers for the disparity search and depth-map writer.
// Tree nodes are sized for the widest supported configuration (WIN=15, MAX_DISP=64).
package disp_pkg;

    localparam int unsigned DefaultMaxDisp = 16;
    localparam int unsigned DefaultWin     = 5;
    localparam int unsigned NodeCostW      = 12;
    localparam int unsigned NodeDispW      = 6;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned cost_w(input int unsigned win);
        return 8 + clog2(win);
    endfunction

    typedef struct packed {
        logic [NodeCostW-1:0] cost;
        logic [NodeCostW-1:0] second;
        logic [NodeDispW-1:0] disp;
    } node_t;

endpackage

// File: rtl/disparity_search_if.sv
// Pixel-in / disparity-out bundle of the disparity search stage.
interface disparity_search_if #(
    parameter int unsigned MAX_DISP = disp_pkg::DefaultMaxDisp,
    parameter int unsigned WIN      = disp_pkg::DefaultWin,
    parameter int unsigned COL_W    = 13
);
    localparam int unsigned DispW = disp_pkg::clog2(MAX_DISP);
    localparam int unsigned CostW = disp_pkg::cost_w(WIN);

    logic             pix_valid;
    logic [7:0]       left_pix;
    logic [7:0]       right_pix;
    logic [COL_W-1:0] col_in;
    logic             disp_valid;
    logic [DispW-1:0] disparity;
    logic [CostW-1:0] cost;
    logic             disp_ok;

    modport master (
        output pix_valid, left_pix, right_pix, col_in,
        input  disp_valid, disparity, cost, disp_ok
    );

    modport slave (
        input  pix_valid, left_pix, right_pix, col_in,
        output disp_valid, disparity, cost, disp_ok
    );

endinterface

// File: rtl/disp_min_tree.sv
// Registered min/argmin tree, one level per clock; heap-indexed, node 1 is the root.
// With DISP_UNIQUENESS_EN each node also tracks the second-best cost.
module disp_min_tree
    import disp_pkg::*;
#(
    parameter int unsigned N = DefaultMaxDisp
) (
    input  logic  clk,
    input  logic  reset,
    input  node_t leaves_i [N],
    output node_t root_o
);

    node_t node_q [1:N-1];
    node_t node_d [1:N-1];
    node_t tree   [1:2*N-1];

    // Left child always covers the smaller disparities, so it keeps ties.
    function automatic node_t merge(input node_t a, input node_t b);
        node_t w;
        node_t l;
        if (b.cost < a.cost) begin
            w = b;
            l = a;
        end else begin
            w = a;
            l = b;
        end
        merge = w;
`ifdef DISP_UNIQUENESS_EN
        merge.second = (l.cost < w.second) ? l.cost : w.second;
`else
        merge.second = w.second & l.second;
`endif
    endfunction

    always_comb begin
        for (int i = 1; i < N; i++) tree[i] = node_q[i];
        for (int d = 0; d < N; d++) tree[N + d] = leaves_i[d];
    end

    always_comb begin
        for (int i = 1; i < N; i++) node_d[i] = merge(tree[2 * i], tree[2 * i + 1]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            node_q <= '{default: '0};
        end else begin
            node_q <= node_d;
        end
    end

    assign root_o = node_q[1];

endmodule

// File: rtl/disparity_search.sv
// Stereo SAD block matcher: input/tap register, AD stage, running window sums, min tree.
// Optional DISP_UNIQUENESS_EN rejects results whose runner-up cost is too close to the best.
module disparity_search
    import disp_pkg::*;
#(
    parameter int unsigned MAX_DISP = DefaultMaxDisp,
    parameter int unsigned WIN      = DefaultWin,
    parameter int unsigned COL_W    = 13
) (
    input logic               clk,
    input logic               reset,
    disparity_search_if.slave bus
);

    localparam int unsigned DispW    = clog2(MAX_DISP);
    localparam int unsigned CostW    = cost_w(WIN);
    localparam int unsigned EdgeCols = (MAX_DISP - 1) + (WIN - 1);
`ifdef DISP_UNIQUENESS_EN
    localparam logic [NodeCostW-1:0] SecondInit = '1;
`else
    localparam logic [NodeCostW-1:0] SecondInit = '0;
`endif

    function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a - b : b - a;
    endfunction

    // S0: input register and right taps
    logic       v0_q, row0_q, edge0_q;
    logic [7:0] left0_q;
    logic [7:0] taps_q [MAX_DISP];
    logic [7:0] taps_d [MAX_DISP];
    logic       row_start;

    assign row_start = bus.pix_valid && (bus.col_in == '0);

    always_comb begin
        taps_d = taps_q;
        if (bus.pix_valid) begin
            taps_d[0] = bus.right_pix;
            for (int d = 1; d < MAX_DISP; d++) taps_d[d] = row_start ? 8'd0 : taps_q[d-1];
        end
    end

    // S1: absolute differences; S2: running window sums
    logic             v1_q, row1_q, edge1_q;
    logic [7:0]       ad1_q  [MAX_DISP];
    logic             v2_q, edge2_q;
    logic [CostW-1:0] sums_q [MAX_DISP];
    logic [CostW-1:0] sums_d [MAX_DISP];
    logic [7:0]       dl_q   [MAX_DISP][WIN];
    logic [7:0]       dl_d   [MAX_DISP][WIN];

    always_comb begin
        sums_d = sums_q;
        dl_d   = dl_q;
        if (v1_q) begin
            for (int d = 0; d < MAX_DISP; d++) begin
                dl_d[d][0] = ad1_q[d];
                for (int k = 1; k < WIN; k++) dl_d[d][k] = row1_q ? 8'd0 : dl_q[d][k-1];
                sums_d[d] = row1_q ? CostW'(ad1_q[d])
                                   : sums_q[d] + CostW'(ad1_q[d]) - CostW'(dl_q[d][WIN-1]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v0_q    <= 1'b0;
            row0_q  <= 1'b0;
            edge0_q <= 1'b0;
            left0_q <= '0;
            taps_q  <= '{default: '0};
            v1_q    <= 1'b0;
            row1_q  <= 1'b0;
            edge1_q <= 1'b0;
            ad1_q   <= '{default: '0};
            v2_q    <= 1'b0;
            edge2_q <= 1'b0;
            sums_q  <= '{default: '0};
            dl_q    <= '{default: '{default: '0}};
        end else begin
            v0_q    <= bus.pix_valid;
            row0_q  <= row_start;
            edge0_q <= bus.col_in < COL_W'(EdgeCols);
            left0_q <= bus.left_pix;
            taps_q  <= taps_d;
            v1_q    <= v0_q;
            row1_q  <= row0_q;
            edge1_q <= edge0_q;
            for (int d = 0; d < MAX_DISP; d++) ad1_q[d] <= absdiff(left0_q, taps_q[d]);
            v2_q    <= v1_q;
            edge2_q <= edge1_q;
            sums_q  <= sums_d;
            dl_q    <= dl_d;
        end
    end

    // S3..: min tree with valid/edge flags riding alongside
    node_t leaves [MAX_DISP];
    node_t root;
    logic  unused_root;

    always_comb begin
        leaves = '{default: '0};
        for (int d = 0; d < MAX_DISP; d++) begin
            leaves[d].cost   = NodeCostW'(sums_q[d]);
            leaves[d].second = SecondInit;
            leaves[d].disp   = NodeDispW'(d);
        end
    end

    disp_min_tree #(
        .N (MAX_DISP)
    ) u_tree (
        .clk      (clk),
        .reset    (reset),
        .leaves_i (leaves),
        .root_o   (root)
    );

    assign unused_root = ^root;

    logic uniq_ok;
`ifdef DISP_UNIQUENESS_EN
    logic [NodeCostW-1:0] gap;
    // A tie with the runner-up counts as ambiguous, so flat patches are rejected.
    always_comb begin
        gap     = root.second - root.cost;
        uniq_ok = gap > (root.cost >> 3);
    end
`else
    assign uniq_ok = 1'b1;
`endif

    logic [DispW-1:0] vp_q, ep_q;
    logic             valid_q, ok_q;
    logic [DispW-1:0] disp_q;
    logic [CostW-1:0] cost_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vp_q    <= '0;
            ep_q    <= '0;
            valid_q <= 1'b0;
            ok_q    <= 1'b0;
            disp_q  <= '0;
            cost_q  <= '0;
        end else begin
            vp_q[0] <= v2_q;
            ep_q[0] <= edge2_q;
            for (int i = 1; i < DispW; i++) begin
                vp_q[i] <= vp_q[i-1];
                ep_q[i] <= ep_q[i-1];
            end
            valid_q <= vp_q[DispW-1];
            ok_q    <= !ep_q[DispW-1] && uniq_ok;
            disp_q  <= root.disp[DispW-1:0];
            cost_q  <= root.cost[CostW-1:0];
        end
    end

    assign bus.disp_valid = valid_q;
    assign bus.disparity  = disp_q;
    assign bus.cost       = cost_q;
    assign bus.disp_ok    = ok_q;

endmodule

// File: tb/tb_disparity_search.sv
// Randomised bench for disparity_search against a per-row SAD reference model.
module tb_disparity_search;
    import disp_pkg::*;

    localparam int unsigned MaxDisp  = 16;
    localparam int unsigned Win      = 5;
    localparam int unsigned DispW    = clog2(MaxDisp);
    localparam int unsigned CostW    = cost_w(Win);
    localparam int          Lat      = 4 + int'(DispW);
    localparam int          EdgeCols = int'(MaxDisp - 1 + Win - 1);

    typedef struct packed {
        logic [31:0]      cyc;
        logic [DispW-1:0] disp;
        logic [CostW-1:0] cost;
        logic             ok;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    disparity_search_if #(.MAX_DISP(MaxDisp), .WIN(Win), .COL_W(13)) bus ();

    disparity_search #(.MAX_DISP(MaxDisp), .WIN(Win), .COL_W(13)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   cyc = 0;
    res_t obs_q[$];
    res_t exp_q[$];
    int   lh[$];
    int   rh[$];
    int   nvec = 0;
    int   nerr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (bus.disp_valid === 1'b1) obs_q.push_back({32'(cyc), bus.disparity, bus.cost, bus.disp_ok});
    end

    // Reference: brute-force SAD over the current row's beat history, zeros before the row.
    function automatic res_t model_beat(input int l, input int r, input int col);
        res_t e;
        int j, s, p, rv, diff, best, bestd, second;
        if (col == 0) begin
            lh.delete();
            rh.delete();
        end
        lh.push_back(l & 255);
        rh.push_back(r & 255);
        j = lh.size() - 1;
        best = 1 << 30;
        second = 1 << 30;
        bestd = 0;
        for (int d = 0; d < int'(MaxDisp); d++) begin
            s = 0;
            for (int k = 0; k < int'(Win); k++) begin
                p = j - k;
                if (p >= 0) begin
                    rv = (p - d >= 0) ? rh[p - d] : 0;
                    diff = lh[p] - rv;
                    s += (diff < 0) ? -diff : diff;
                end
            end
            if (s < best) begin
                second = best;
                best = s;
                bestd = d;
            end else if (s < second) begin
                second = s;
            end
        end
        e.cyc  = '0;
        e.disp = DispW'(bestd);
        e.cost = CostW'(best);
        e.ok   = col >= EdgeCols;
`ifdef DISP_UNIQUENESS_EN
        e.ok = e.ok && ((second - best) > (best >> 3));
`endif
        return e;
    endfunction

    task automatic drive(input logic v, input int l, input int r, input int col);
        res_t e;
        bus.pix_valid = v;
        bus.left_pix  = 8'(l);
        bus.right_pix = 8'(r);
        bus.col_in    = 13'(col);
        @(posedge clk);
        #1;
        if (v) begin
            e = model_beat(l, r, col);
            e.cyc = 32'(cyc + Lat - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0, 0);
    endtask

    task automatic start_test();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic run_ramp(input int len, input int pct_valid);
        for (int c = 0; c < len; c++) begin
            while (int'($urandom_range(0, 99)) >= pct_valid) drive(1'b0, 0, 0, 0);
            drive(1'b1, (c * 3) % 256, ((c * 3 - 15) % 256 + 256) % 256, c);
        end
    endtask

    task automatic run_row(input int len, input int shift, input int pct_valid, input int noise);
        int lrow[];
        int rv;
        lrow = new[len];
        for (int c = 0; c < len; c++) lrow[c] = int'($urandom_range(0, 255));
        for (int c = 0; c < len; c++) begin
            rv = (c >= shift) ? lrow[c - shift] + int'($urandom_range(0, noise))
                              : int'($urandom_range(0, 255));
            while (int'($urandom_range(0, 99)) >= pct_valid) drive(1'b0, 0, 0, 0);
            drive(1'b1, lrow[c], rv & 255, c);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.pix_valid = 1'b0;
        bus.left_pix = '0;
        bus.right_pix = '0;
        bus.col_in = '0;
        #3;
        nvec += 4;
        if (bus.disp_valid !== 1'b0) begin
            nerr++;
            $display("FAIL reset_valid: got %b, expected 0", bus.disp_valid);
        end
        if (bus.disparity !== '0) begin
            nerr++;
            $display("FAIL reset_disparity: got %0d, expected 0", bus.disparity);
        end
        if (bus.cost !== '0) begin
            nerr++;
            $display("FAIL reset_cost: got %0d, expected 0", bus.cost);
        end
        if (bus.disp_ok !== 1'b0) begin
            nerr++;
            $display("FAIL reset_ok: got %b, expected 0", bus.disp_ok);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        start_test();
        idle(Lat + 2);
        nvec++;
        if (obs_q.size() != 0) begin
            nerr++;
            $display("FAIL reset_idle: got %0d results, expected 0", obs_q.size());
        end
    endtask

    task automatic test_flat();
        int nok, nbad;
        start_test();
        for (int c = 0; c < 640; c++) drive(1'b1, 100, 100, c);
        idle(Lat + 2);
        nvec++;
        if (obs_q.size() != exp_q.size()) begin
            nerr++;
            $display("FAIL flat count: got %0d results, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            nvec++;
            if (obs_q[i] !== exp_q[i]) begin
                nerr++;
                $display("FAIL flat[%0d]: got cyc=%0d disp=%0d cost=%0d ok=%0b, expected cyc=%0d disp=%0d cost=%0d ok=%0b",
                         i, obs_q[i].cyc, obs_q[i].disp, obs_q[i].cost, obs_q[i].ok,
                         exp_q[i].cyc, exp_q[i].disp, exp_q[i].cost, exp_q[i].ok);
            end
        end
        nok = 0;
        nbad = 0;
        foreach (obs_q[i]) begin
            if (obs_q[i].ok) nok++;
            if (obs_q[i].disp != 0 || obs_q[i].cost != 0) nbad++;
        end
        nvec++;
        if (nbad != 0) begin
            nerr++;
            $display("FAIL flat_zero: got %0d nonzero results, expected 0", nbad);
        end
`ifndef DISP_UNIQUENESS_EN
        nvec++;
        if (nok != 640 - EdgeCols) begin
            nerr++;
            $display("FAIL flat_ok_count: got %0d, expected %0d", nok, 640 - EdgeCols);
        end
`endif
    endtask

    task automatic test_ramp_shift();
        start_test();
        run_ramp(300, 100);
        idle(Lat + 2);
        nvec++;
        if (obs_q.size() != exp_q.size()) begin
            nerr++;
            $display("FAIL ramp count: got %0d results, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            nvec++;
            if (obs_q[i] !== exp_q[i]) begin
                nerr++;
                $display("FAIL ramp[%0d]: got cyc=%0d disp=%0d cost=%0d ok=%0b, expected cyc=%0d disp=%0d cost=%0d ok=%0b",
                         i, obs_q[i].cyc, obs_q[i].disp, obs_q[i].cost, obs_q[i].ok,
                         exp_q[i].cyc, exp_q[i].disp, exp_q[i].cost, exp_q[i].ok);
            end
        end
    endtask

    task automatic test_bubbles();
        start_test();
        run_ramp(300, 70);
        idle(Lat + 2);
        nvec++;
        if (obs_q.size() != exp_q.size()) begin
            nerr++;
            $display("FAIL bubbles count: got %0d results, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            nvec++;
            if (obs_q[i] !== exp_q[i]) begin
                nerr++;
                $display("FAIL bubbles[%0d]: got cyc=%0d disp=%0d cost=%0d ok=%0b, expected cyc=%0d disp=%0d cost=%0d ok=%0b",
                         i, obs_q[i].cyc, obs_q[i].disp, obs_q[i].cost, obs_q[i].ok,
                         exp_q[i].cyc, exp_q[i].disp, exp_q[i].cost, exp_q[i].ok);
            end
        end
    endtask

    task automatic test_row_restart();
        start_test();
        run_row(300, 7, 100, 2);
        run_row(80, 3, 85, 2);
        for (int n = 0; n < 3; n++) run_row(40 + int'($urandom_range(0, 80)),
                                             int'($urandom_range(0, MaxDisp - 1)), 75, 3);
        idle(Lat + 2);
        nvec++;
        if (obs_q.size() != exp_q.size()) begin
            nerr++;
            $display("FAIL restart count: got %0d results, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            nvec++;
            if (obs_q[i] !== exp_q[i]) begin
                nerr++;
                $display("FAIL restart[%0d]: got cyc=%0d disp=%0d cost=%0d ok=%0b, expected cyc=%0d disp=%0d cost=%0d ok=%0b",
                         i, obs_q[i].cyc, obs_q[i].disp, obs_q[i].cost, obs_q[i].ok,
                         exp_q[i].cyc, exp_q[i].disp, exp_q[i].cost, exp_q[i].ok);
            end
        end
    endtask

    task automatic test_reset_inflight();
        start_test();
        run_row(30, 4, 100, 2);
        idle(1);
        #2;
        reset = 1'b1;
        #1;
        nvec++;
        if ({bus.disp_valid, bus.disparity, bus.cost, bus.disp_ok} !== '0) begin
            nerr++;
            $display("FAIL inflight_async: got valid=%b disp=%0d cost=%0d ok=%b, expected all 0",
                     bus.disp_valid, bus.disparity, bus.cost, bus.disp_ok);
        end
        while (exp_q.size() > 0 && int'(exp_q[exp_q.size() - 1].cyc) > cyc) void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);
        run_row(60, 9, 100, 1);
        idle(Lat + 2);
        nvec++;
        if (obs_q.size() != exp_q.size()) begin
            nerr++;
            $display("FAIL inflight count: got %0d results, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            nvec++;
            if (obs_q[i] !== exp_q[i]) begin
                nerr++;
                $display("FAIL inflight[%0d]: got cyc=%0d disp=%0d cost=%0d ok=%0b, expected cyc=%0d disp=%0d cost=%0d ok=%0b",
                         i, obs_q[i].cyc, obs_q[i].disp, obs_q[i].cost, obs_q[i].ok,
                         exp_q[i].cyc, exp_q[i].disp, exp_q[i].cost, exp_q[i].ok);
            end
        end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_ramp_shift();
        test_bubbles();
        test_row_restart();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
